// File: rtl/clock_ctrl_if.sv
// clock_ctrl_if: button inputs and control outputs of the clock controller
interface clock_ctrl_if;
    logic btn_mode, btn_min, btn_hour;
    logic start, inc_min_auto, inc_min, inc_hour, blink;
    modport master (
        output btn_mode, btn_min, btn_hour,
        input  start, inc_min_auto, inc_min, inc_hour, blink
    );
    modport slave (
        input  btn_mode, btn_min, btn_hour,
        output start, inc_min_auto, inc_min, inc_hour, blink
    );
endinterface

// File: rtl/clock_ctrl.sv
// clock_ctrl: debounced mode/min/hour buttons driving a SET/RUN FSM with auto-repeat,
// a minute prescaler and a display-blink generator; every output comes straight from a flop
module clock_ctrl #(
    parameter int unsigned TICKS_PER_MIN = 60,
    parameter int unsigned DEBOUNCE_CYC  = 4,
    parameter int unsigned REPEAT_DELAY  = 20,
    parameter int unsigned REPEAT_RATE   = 5,
    parameter int unsigned BLINK_CYC     = 8
) (
    input logic         clk,
    input logic         rst,
    clock_ctrl_if.slave bus
);
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam int BW = $clog2(BLINK_CYC + 1);

    typedef enum logic {SET, RUN} state_e;

    state_e        state_q;
    logic          start_q, inc_min_q, inc_hour_q, auto_q, blink_q;
    logic [31:0]   presc_q;
    logic [BW-1:0] bcnt_q;
    logic [2:0]    raw, lvl_q, prev_q, rise;
    logic [15:0]   db_q [3];
    logic [RW-1:0] rep_q [2];
    logic [1:0]    rpt_q, fire;
    logic          mode_ev, run, wrap, bend;

    // bit 0 = mode, 1 = minute, 2 = hour
    assign raw  = {bus.btn_hour, bus.btn_min, bus.btn_mode};
    assign rise = lvl_q & ~prev_q;

    always_comb begin
        mode_ev = rise[0];
        run     = state_q == RUN;
        wrap    = presc_q == 32'(TICKS_PER_MIN - 1);
        bend    = bcnt_q == BW'(BLINK_CYC - 1);
        fire    = '0;
        for (int i = 0; i < 2; i++)
            fire[i] = lvl_q[i+1] && (rise[i+1] ||
                      rep_q[i] == (rpt_q[i] ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1)));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                db_q[i]   <= '0;
                lvl_q[i]  <= 1'b0;
                prev_q[i] <= 1'b0;
            end else begin
                prev_q[i] <= lvl_q[i];
                db_q[i]   <= (raw[i] == lvl_q[i] || db_q[i] == 16'(DEBOUNCE_CYC - 1)) ? '0 : db_q[i] + 16'd1;
                if (raw[i] != lvl_q[i] && db_q[i] == 16'(DEBOUNCE_CYC - 1))
                    lvl_q[i] <= raw[i];
            end
        end
    end

    // rpt_q selects the repeat period: initial delay after a press, then the rate
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst || run || mode_ev || !lvl_q[i+1]) begin
                rep_q[i] <= '0;
                rpt_q[i] <= 1'b0;
            end else begin
                rep_q[i] <= fire[i] ? '0 : rep_q[i] + RW'(1);
                rpt_q[i] <= fire[i] ? !rise[i+1] : rpt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SET;
            start_q    <= 1'b0;
            inc_min_q  <= 1'b0;
            inc_hour_q <= 1'b0;
            auto_q     <= 1'b0;
            blink_q    <= 1'b1;
            presc_q    <= '0;
            bcnt_q     <= '0;
        end else begin
            state_q    <= (run ^ mode_ev) ? RUN : SET;
            start_q    <= run ^ mode_ev;
            inc_min_q  <= !run && !mode_ev && fire[0];
            inc_hour_q <= !run && !mode_ev && fire[1];
            auto_q     <= run && !mode_ev && wrap;
            presc_q    <= (run && !mode_ev && !wrap) ? presc_q + 32'd1 : '0;
            blink_q    <= run ? mode_ev : !mode_ev && (blink_q ^ bend);
            bcnt_q     <= (run || mode_ev || bend) ? '0 : bcnt_q + BW'(1);
        end
    end

    assign bus.start        = start_q;
    assign bus.inc_min      = inc_min_q;
    assign bus.inc_hour     = inc_hour_q;
    assign bus.inc_min_auto = auto_q;
    assign bus.blink        = blink_q;
endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: directed stimulus pushes expected pulses (kind, cycle) into a scoreboard;
// a negedge monitor pops one entry for every pulse the DUT emits
module tb_clock_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct { int kind; int at; } exp_t;
    exp_t sb[$];

    clock_ctrl_if bus();

    clock_ctrl #(
        .TICKS_PER_MIN(10), .DEBOUNCE_CYC(4), .REPEAT_DELAY(20),
        .REPEAT_RATE(5), .BLINK_CYC(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_pulse(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0b required %0b at cyc %0d", name, act, req, cyc);
        end
    endtask

    // kind: 0 = inc_min, 1 = inc_hour, 2 = inc_min_auto
    task automatic got_pulse(input int kind);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL pulse: actual kind %0d at cyc %0d, required none", kind, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.at != cyc) begin
                errors++;
                $display("FAIL pulse: actual kind %0d at cyc %0d, required kind %0d at cyc %0d",
                         kind, cyc, e.kind, e.at);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.inc_min === 1'b1) got_pulse(0);
        if (bus.inc_hour === 1'b1) got_pulse(1);
        if (bus.inc_min_auto === 1'b1) got_pulse(2);
    end

    initial begin
        #200000;
        $display("FAIL timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        bus.btn_mode = 1'b0;
        bus.btn_min  = 1'b0;
        bus.btn_hour = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_start", bus.start, 1'b0);
        check("rst_blink", bus.blink, 1'b1);
        check("rst_inc_min", bus.inc_min, 1'b0);
        check("rst_inc_hour", bus.inc_hour, 1'b0);
        check("rst_auto", bus.inc_min_auto, 1'b0);
        repeat (7) @(negedge clk);
        check("blink_hold", bus.blink, 1'b1);
        @(negedge clk);
        check("blink_toggle", bus.blink, 1'b0);
        repeat (8) @(negedge clk);
        check("blink_retoggle", bus.blink, 1'b1);

        // single minute press
        base = cyc;
        bus.btn_min = 1'b1;
        expect_pulse(0, base + 5);
        repeat (10) @(negedge clk);
        bus.btn_min = 1'b0;
        check("set_start", bus.start, 1'b0);
        repeat (10) @(negedge clk);

        // bouncing minute button
        for (int i = 0; i < 30; i++) begin
            bus.btn_min = ~bus.btn_min;
            @(negedge clk);
        end
        bus.btn_min = 1'b0;
        repeat (10) @(negedge clk);

        // hour held: initial pulse plus auto-repeat
        base = cyc;
        bus.btn_hour = 1'b1;
        expect_pulse(1, base + 5);
        for (int i = 20; i <= 45; i += 5) expect_pulse(1, base + 5 + i);
        repeat (50) @(negedge clk);
        bus.btn_hour = 1'b0;
        repeat (10) @(negedge clk);

        // enter RUN, minute ticks, ignored minute press, leave RUN on a wrap cycle
        base = cyc;
        bus.btn_mode = 1'b1;
        for (int i = 15; i <= 35; i += 10) expect_pulse(2, base + i);
        repeat (5) @(negedge clk);
        check("run_start", bus.start, 1'b1);
        check("run_blink", bus.blink, 1'b0);
        @(negedge clk);
        bus.btn_mode = 1'b0;
        repeat (2) @(negedge clk);
        bus.btn_min = 1'b1;
        repeat (6) @(negedge clk);
        bus.btn_min = 1'b0;
        repeat (26) @(negedge clk);
        bus.btn_mode = 1'b1;
        repeat (5) @(negedge clk);
        check("set_again_start", bus.start, 1'b0);
        check("set_again_blink", bus.blink, 1'b1);
        @(negedge clk);
        bus.btn_mode = 1'b0;
        repeat (15) @(negedge clk);

        // mode and minute rise together: mode wins
        base = cyc;
        bus.btn_mode = 1'b1;
        bus.btn_min  = 1'b1;
        expect_pulse(2, base + 15);
        repeat (5) @(negedge clk);
        check("both_start", bus.start, 1'b1);
        check("both_inc_min", bus.inc_min, 1'b0);
        repeat (3) @(negedge clk);
        bus.btn_mode = 1'b0;
        bus.btn_min  = 1'b0;
        repeat (14) @(negedge clk);

        // reset seven cycles into a minute
        rst = 1'b1;
        @(negedge clk);
        check("rst_run_start", bus.start, 1'b0);
        check("rst_run_blink", bus.blink, 1'b1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // re-enter RUN: full minute before first tick
        base = cyc;
        bus.btn_mode = 1'b1;
        expect_pulse(2, base + 15);
        expect_pulse(2, base + 25);
        repeat (5) @(negedge clk);
        check("rerun_start", bus.start, 1'b1);
        @(negedge clk);
        bus.btn_mode = 1'b0;
        repeat (24) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d pending pulses, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clock_ctrl.md
CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 Parameter TICKS_PER_MIN, default 60, SHALL set the clk cycles per automatic minute pulse in RUN; legal range 2..2^32-1.
REQ-002 Parameter DEBOUNCE_CYC, default 4, SHALL set the consecutive-sample count needed to accept a button level change; legal range 2..2^16-1.
REQ-003 Parameter REPEAT_DELAY, default 20, SHALL set the hold time in cycles before auto-repeat starts; legal range > REPEAT_RATE.
REQ-004 Parameter REPEAT_RATE, default 5, SHALL set the auto-repeat period in cycles; legal range >= 2.
REQ-005 Parameter BLINK_CYC, default 8, SHALL set the blink half-period in cycles; legal range >= 1.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 btn_mode  input  1  raw mode button, active-high, already synchronous to clk.
REQ-009 btn_min  input  1  raw minute-set button, active-high, synchronous to clk.
REQ-010 btn_hour  input  1  raw hour-set button, active-high, synchronous to clk.
REQ-011 start  output  1  1 = RUN (counter free-runs), 0 = SET.
REQ-012 inc_min_auto  output  1  one-cycle minute-elapsed pulse, RUN only.
REQ-013 inc_min  output  1  one-cycle manual minute increment, SET only.
REQ-014 inc_hour  output  1  one-cycle manual hour increment, SET only.
REQ-015 blink  output  1  display-blink enable: toggles in SET, 0 in RUN.

Function
REQ-016 All outputs SHALL be driven directly from flops.
REQ-017 Each button SHALL have an independent debouncer: a counter increments while raw != debounced level and clears while raw == debounced; when it reaches DEBOUNCE_CYC-1 and raw still differs, the debounced level takes raw and the counter clears.
REQ-018 A press event SHALL be a 0->1 transition of a debounced level; release (1->0) SHALL generate no event.
REQ-019 With raw held high from edge k, the press event SHALL appear on an output one cycle after the debounced level rises, i.e. high for exactly the cycle following edge k+DEBOUNCE_CYC.
REQ-020 The FSM SHALL have two states, SET (start=0) and RUN (start=1); a btn_mode press event SHALL toggle the state.
REQ-021 A btn_mode press event SHALL take priority: any min/hour event in the same cycle SHALL be discarded, and inc_min, inc_hour, inc_min_auto SHALL be 0 in that cycle.
REQ-022 In SET, a btn_min press SHALL produce one inc_min pulse; a btn_hour press SHALL produce one inc_hour pulse; simultaneous events SHALL pulse both in the same cycle.
REQ-023 In SET, while a debounced min/hour level stays high, auto-repeat SHALL emit further pulses REPEAT_DELAY cycles after the initial pulse, then every REPEAT_RATE cycles, until release; min and hour repeat counters SHALL be independent.
REQ-024 In RUN, inc_min and inc_hour SHALL be 0 and min/hour events SHALL be ignored (no queueing); repeat counters SHALL be held at 0.
REQ-025 A 32-bit prescaler SHALL clear on every SET->RUN transition and be held at 0 in SET.
REQ-026 In RUN the prescaler SHALL count 0..TICKS_PER_MIN-1 and wrap; inc_min_auto SHALL pulse for exactly one cycle in the cycle after the prescaler reaches TICKS_PER_MIN-1, so the first pulse follows TICKS_PER_MIN cycles after start rises.
REQ-027 A RUN->SET transition SHALL discard any partial minute; no inc_min_auto SHALL be emitted after start falls.
REQ-028 In SET, blink SHALL toggle every BLINK_CYC cycles, starting at 1 on SET entry; in RUN blink SHALL be 0.

Reset
REQ-029 While rst is 1 at a clock edge: state=SET, start=0, inc_min=0, inc_hour=0, inc_min_auto=0, blink=1; prescaler, debounce, repeat and blink counters=0; debounced levels=0.
REQ-030 Reset SHALL override any in-progress debounce, repeat or minute count; a button held through reset deassertion SHALL be treated as a new press after DEBOUNCE_CYC cycles.

Verification (TICKS_PER_MIN=10, DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_RATE=5)
REQ-031 After reset, btn_min high from edge 0 for 10 cycles -> exactly one inc_min pulse, in the cycle after edge 4; start=0.
REQ-032 btn_min toggling every cycle for 30 cycles -> no inc_min pulse.
REQ-033 btn_hour held 50 cycles in SET -> inc_hour pulses at offsets 0, 20, 25, 30, 35, 40, 45 relative to the first pulse, none after release.
REQ-034 btn_mode press -> start=1; over 35 cycles inc_min_auto pulses 3 times, spaced exactly 10 cycles, the first 10 cycles after start rises; btn_min presses in RUN yield no inc_min.
REQ-035 btn_mode and btn_min debounced-rise in the same cycle in SET -> start=1, inc_min stays 0.
REQ-036 rst asserted 7 cycles into a RUN minute -> start=0 next cycle; after re-entering RUN, first inc_min_auto comes 10 full cycles after start rises.
